logic_unit_serial: RTL

//   Parametrised, handshaked successor to the 2-input selectable logic gate.

---
 rtl/logic_unit_serial_if.sv | 26 ++
 rtl/logic_unit_serial.sv | 116 +++++++++++
 2 files changed

// File: rtl/logic_unit_serial_if.sv
// Operand/result handshake bundle for logic_unit_serial.
// The producer/consumer side uses the master modport; the unit uses slave.
interface logic_unit_serial_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       sel;
   logic             acc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;
   logic             zero;

   modport master (
      output in_valid, a, b, sel, acc, out_ready,
      input  in_ready, out_valid, out, zero
   );

   modport slave (
      input  in_valid, a, b, sel, acc, out_ready,
      output in_ready, out_valid, out, zero
   );
endinterface

// File: rtl/logic_unit_serial.sv
// Serial selectable logic unit: evaluates one of 8 bitwise ops on WIDTH-bit
// operands, SLICE bits per cycle, LSB slice first. Accumulate mode feeds the
// last completed result back in as operand b.
module logic_unit_serial #(
   parameter int WIDTH = 8,
   parameter int SLICE = 2
) (
   input logic               clk,
   input logic               rst,
   logic_unit_serial_if.slave bus
);
   localparam int STEPS = WIDTH / SLICE;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

   generate
      if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_slice
         $error("logic_unit_serial: WIDTH must be a multiple of SLICE");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [2:0]       op_sel;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] work_next;
   logic [WIDTH-1:0] out_r;
   logic [CNT_W-1:0] count;
   logic [SLICE-1:0] slice_res;
   logic             last_step;

   // One slice of the selected bitwise op; codes 6 and 7 both mean NOT a.
   function automatic logic [SLICE-1:0] slice_op(input logic [2:0]       s,
                                                  input logic [SLICE-1:0] x,
                                                  input logic [SLICE-1:0] y);
      case (s)
         3'd0:    return ~(x & y);
         3'd1:    return x & y;
         3'd2:    return x | y;
         3'd3:    return ~(x | y);
         3'd4:    return x ^ y;
         3'd5:    return ~(x ^ y);
         default: return ~x;
      endcase
   endfunction

   // Current slice result and the working result with that slice merged in.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      work_next = work;
      slice_res = slice_op(op_sel, op_a[count*SLICE +: SLICE], op_b[count*SLICE +: SLICE]);
      work_next[count*SLICE +: SLICE] = slice_res;
      last_step = (count == CNT_W'(STEPS - 1));
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic: accept in IDLE, evaluate STEPS slices, hold result until taken.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.in_valid)  state_next = BUSY;
         BUSY:    if (last_step)     state_next = DONE;
         DONE:    if (bus.out_ready) state_next = IDLE;
         default:                    state_next = IDLE;
      endcase
   end

   // Datapath: operand capture on accept, slice evaluation, result load on the last step.
   always_ff @(posedge clk) begin
      // NOTE: all datapath registers are reset so acc straight after reset reads a defined zero.
      if (rst) begin
         op_a   <= '0;
         op_b   <= '0;
         op_sel <= '0;
         work   <= '0;
         out_r  <= '0;
         count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  op_a   <= bus.a;
                  op_b   <= bus.acc ? out_r : bus.b;
                  op_sel <= bus.sel;
                  work   <= '0;
                  count  <= '0;
               end
            end
            BUSY: begin
               work  <= work_next;
               count <= last_step ? '0 : count + 1'b1;
               if (last_step) out_r <= work_next;
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out       = out_r;
   assign bus.zero      = (out_r == '0);
endmodule
